mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning consecutive denied cycles after which requester B gets priority (range 1..255).
REQ-002 SHALL have port clk  input  1  the system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; state is cleared while it is 0.
REQ-004 SHALL have ports a_req, b_req  input  1 each  access request from requester A (CPU data side) or B (loader/DMA).
REQ-005 SHALL have ports a_wen, b_wen  input  4 each  byte write enables; 4'b0000 means read.
REQ-006 SHALL have ports a_addr, b_addr, a_wdata, b_wdata  input  32 each  address and write data.
REQ-007 SHALL have port b_lock  input  1  B keeps ownership across consecutive requests while asserted.
REQ-008 SHALL have ports a_gnt, b_gnt  output  1 each  access accepted this cycle.
REQ-009 SHALL have ports a_rvalid, b_rvalid  output  1 each  read data valid for that requester.
REQ-010 SHALL have ports a_rdata, b_rdata  output  32 each  read data returned.
REQ-011 SHALL have ports mem_raddr  output  32, mem_rdata  input  32, mem_wen  output  4, mem_waddr  output  32, mem_wdata  output  32, driving the shared memory data port.

Function
REQ-012 SHALL grant at most one requester per cycle; a_gnt & b_gnt never both 1.
REQ-013 SHALL decide grant combinationally in the request cycle; the granted requester's addr drives mem_raddr/mem_waddr, and wen/wdata drive mem_wen/mem_wdata that cycle.
REQ-014 SHALL drive mem_wen = 4'b0000 in any cycle with no grant or a read grant.
REQ-015 SHALL keep a 3-state owner FSM: IDLE (no grant last cycle), OWN_A, OWN_B; next state = owner of this cycle's grant, else IDLE.
REQ-016 SHALL use default priority A over B.
REQ-017 SHALL give B priority when wait_cnt == MAX_WAIT, or when state is OWN_B and b_lock is 1 and b_req is 1.
REQ-018 SHALL increment the 8-bit wait_cnt each cycle b_req=1 and b_gnt=0, saturating at MAX_WAIT; clear it on b_gnt or when b_req=0.
REQ-019 SHALL register the owner of a read grant; the following cycle assert that requester's rvalid for exactly one cycle, with rdata = mem_rdata (fixed 1-cycle memory latency).
REQ-020 SHALL hold a_rdata/b_rdata at 0 whenever the corresponding rvalid is 0.
REQ-021 SHALL support back-to-back grants every cycle, including alternating owners, with no bubble.
REQ-022 SHALL ignore b_lock when the state is not OWN_B.

Reset
REQ-023 SHALL, with reset=0, force state IDLE, wait_cnt 0, pending-read owner cleared, all gnt/rvalid 0, mem_wen 0, all other outputs 0.
REQ-024 SHALL discard a read granted in the cycle reset asserts; no rvalid follows after release.

Configuration
REQ-025 SHALL, with MEMARB_STATS_EN defined, add output ports a_grants and b_grants (32 bits each, wrapping counts of grants, reset to 0) and a 16-bit max_wait output holding the largest wait_cnt reached.
REQ-026 SHALL, without MEMARB_STATS_EN, omit those ports and counters with function otherwise identical.

Structure
REQ-027 SHALL take the owner-state enum (IDLE/OWN_A/OWN_B) and the read-latency constant (1) from the shared dioptase package.
REQ-028 SHALL place grant selection and the wait counter in one sub-module, memarb_sel; datapath muxing and read-return logic stay in mem_port_arb.

Verification
REQ-029 Both req=1 in the same cycle with wait_cnt=0 -> a_gnt=1, b_gnt=0; B waits.
REQ-030 a_req held 1 every cycle, b_req=1 from cycle 0, MAX_WAIT=4 -> b_gnt=1 exactly at cycle 4; wait_cnt then 0; A regranted at cycle 5.
REQ-031 B read of 0x100 granted with mem_rdata=0xDEADBEEF next cycle -> b_rvalid=1, b_rdata=0xDEADBEEF for one cycle; a_rvalid stays 0.
REQ-032 B granted with b_lock=1 for 3 consecutive requests while a_req=1 -> b_gnt three cycles in a row; A granted the cycle b_lock drops.
REQ-033 A write, wen=4'b0011, addr 0x20, data 0x12345678 -> mem_wen=4'b0011, mem_waddr=0x20, mem_wdata=0x12345678 the same cycle; no rvalid.
REQ-034 reset pulsed low in the cycle of a pending A read -> a_rvalid never asserts; all outputs 0 while reset=0.

Source files
------------

// File: rtl/dioptase_pkg.sv
// rtl/dioptase_pkg.sv - shared owner-state enum and memory read latency for the dioptase memory port
package dioptase_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/memarb_sel.sv
// rtl/memarb_sel.sv - grant selection, owner FSM and B starvation counter (optional stats: MEMARB_STATS_EN)
module memarb_sel
    import dioptase_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        b_lock,
    output logic        a_gnt,
    output logic        b_gnt
`ifdef MEMARB_STATS_EN
    ,
    output logic [31:0] a_grants,
    output logic [31:0] b_grants,
    output logic [15:0] max_wait
`endif
);

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    owner_t     state;
    logic [7:0] wait_cnt;
    logic       b_pri;

    // Grants are gated by reset so every output reads 0 while reset is held low.
    always_comb begin
        b_pri = (wait_cnt == WAIT_LIM) || ((state == OWN_B) && b_lock && b_req);
        a_gnt = reset && a_req && !(b_pri && b_req);
        b_gnt = reset && b_req && (b_pri || !a_req);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            if (a_gnt)
                state <= OWN_A;
            else if (b_gnt)
                state <= OWN_B;
            else
                state <= IDLE;

            if (!b_req || b_gnt)
                wait_cnt <= 8'd0;
            else if (wait_cnt != WAIT_LIM)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

`ifdef MEMARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_grants <= 32'd0;
            b_grants <= 32'd0;
            max_wait <= 16'd0;
        end else begin
            a_grants <= a_grants + {31'd0, a_gnt};
            b_grants <= b_grants + {31'd0, b_gnt};
            if ({8'd0, wait_cnt} > max_wait)
                max_wait <= {8'd0, wait_cnt};
        end
    end
`endif

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - two-requester shared memory port arbiter with read return (optional stats: MEMARB_STATS_EN)
module mem_port_arb
    import dioptase_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        b_req,
    input  logic [3:0]  a_wen,
    input  logic [3:0]  b_wen,
    input  logic [31:0] a_addr,
    input  logic [31:0] b_addr,
    input  logic [31:0] a_wdata,
    input  logic [31:0] b_wdata,
    input  logic        b_lock,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [31:0] a_rdata,
    output logic [31:0] b_rdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata
`ifdef MEMARB_STATS_EN
    ,
    output logic [31:0] a_grants,
    output logic [31:0] b_grants,
    output logic [15:0] max_wait
`endif
);

    owner_t rd_issue;
    owner_t rd_pipe [RD_LATENCY];

    memarb_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .b_req    (b_req),
        .b_lock   (b_lock),
        .a_gnt    (a_gnt),
        .b_gnt    (b_gnt)
`ifdef MEMARB_STATS_EN
        ,
        .a_grants (a_grants),
        .b_grants (b_grants),
        .max_wait (max_wait)
`endif
    );

    always_comb begin
        mem_raddr = 32'd0;
        mem_waddr = 32'd0;
        mem_wen   = 4'd0;
        mem_wdata = 32'd0;
        rd_issue  = IDLE;
        if (a_gnt) begin
            mem_raddr = a_addr;
            mem_waddr = a_addr;
            mem_wen   = a_wen;
            mem_wdata = a_wdata;
            rd_issue  = (a_wen == 4'd0) ? OWN_A : IDLE;
        end else if (b_gnt) begin
            mem_raddr = b_addr;
            mem_waddr = b_addr;
            mem_wen   = b_wen;
            mem_wdata = b_wdata;
            rd_issue  = (b_wen == 4'd0) ? OWN_B : IDLE;
        end
    end

    // Tracks which requester owns the read data arriving after the memory latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LATENCY; i++)
                rd_pipe[i] <= IDLE;
        end else begin
            rd_pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    always_comb begin
        a_rvalid = (rd_pipe[RD_LATENCY-1] == OWN_A);
        b_rvalid = (rd_pipe[RD_LATENCY-1] == OWN_B);
        a_rdata  = a_rvalid ? mem_rdata : 32'd0;
        b_rdata  = b_rvalid ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - scoreboard testbench for mem_port_arb
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req, b_lock;
    logic [3:0]  a_wen, b_wen;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic [3:0]  mem_wen;
`ifdef MEMARB_STATS_EN
    logic [31:0] a_grants, b_grants;
    logic [15:0] max_wait;
`endif

    int checks = 0;
    int errors = 0;
    int cnt    = 0;
    logic [31:0] last_raddr = 32'd0;

    typedef struct {
        int          who;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gexp_t;

    typedef struct {
        int          who;
        logic [31:0] data;
        int          due;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    mem_port_arb #(.MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .b_req     (b_req),
        .a_wen     (a_wen),
        .b_wen     (b_wen),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .a_wdata   (a_wdata),
        .b_wdata   (b_wdata),
        .b_lock    (b_lock),
        .a_gnt     (a_gnt),
        .b_gnt     (b_gnt),
        .a_rvalid  (a_rvalid),
        .b_rvalid  (b_rvalid),
        .a_rdata   (a_rdata),
        .b_rdata   (b_rdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
`ifdef MEMARB_STATS_EN
        ,
        .a_grants  (a_grants),
        .b_grants  (b_grants),
        .max_wait  (max_wait)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: one-cycle read latency on the address presented last cycle.
    always @(posedge clk) begin
        last_raddr <= mem_raddr;
        cnt        <= cnt + 1;
    end
    assign mem_rdata = memf(last_raddr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        logic [167:0] v;
        v = {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
             mem_raddr, mem_wen, mem_waddr, mem_wdata};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s actual=%0h required=0", nm, v);
        end
    endtask

    always @(negedge clk) begin
        chk("gnt_exclusive", {63'd0, a_gnt & b_gnt}, 64'd0);
        if (a_gnt || b_gnt) begin
            if (gq.size() == 0) begin
                chk("unexpected_grant", {62'd0, b_gnt, a_gnt}, 64'd0);
            end else begin
                gexp_t g;
                g = gq.pop_front();
                chk("grant_who", {62'd0, b_gnt, a_gnt}, (g.who == 1) ? 64'd1 : 64'd2);
                chk("mem_wen", {60'd0, mem_wen}, {60'd0, g.wen});
                chk("mem_raddr", {32'd0, mem_raddr}, {32'd0, g.addr});
                chk("mem_waddr", {32'd0, mem_waddr}, {32'd0, g.addr});
                chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, g.wdata});
            end
        end else begin
            chk("idle_mem_wen", {60'd0, mem_wen}, 64'd0);
            if (gq.size() != 0) begin
                gexp_t g;
                g = gq.pop_front();
                chk("missing_grant", 64'd0, (g.who == 1) ? 64'd1 : 64'd2);
            end
        end

        if (!a_rvalid) chk("a_rdata_idle_zero", {32'd0, a_rdata}, 64'd0);
        if (!b_rvalid) chk("b_rdata_idle_zero", {32'd0, b_rdata}, 64'd0);
        if (a_rvalid || b_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", {62'd0, b_rvalid, a_rvalid}, 64'd0);
            end else begin
                rexp_t r;
                r = rq.pop_front();
                chk("rvalid_who", {62'd0, b_rvalid, a_rvalid}, (r.who == 1) ? 64'd1 : 64'd2);
                chk("rvalid_cycle", 64'(cnt), 64'(r.due));
                chk("rdata", {32'd0, (r.who == 1) ? a_rdata : b_rdata}, {32'd0, r.data});
            end
        end else if (rq.size() != 0 && rq[0].due <= cnt) begin
            rexp_t r;
            r = rq.pop_front();
            chk("missing_rvalid", 64'd0, {32'd0, r.data});
        end
    end

    // exp: 0 = no grant, 1 = A, 2 = B
    task automatic cyc(input logic ar, input logic [3:0] aw, input logic [31:0] aa, input logic [31:0] ad,
                       input logic br, input logic [3:0] bw, input logic [31:0] ba, input logic [31:0] bd,
                       input logic bl, input int exp);
        gexp_t g;
        rexp_t r;
        a_req = ar; a_wen = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_wen = bw; b_addr = ba; b_wdata = bd;
        b_lock = bl;
        if (exp != 0) begin
            g.who   = exp;
            g.wen   = (exp == 1) ? aw : bw;
            g.addr  = (exp == 1) ? aa : ba;
            g.wdata = (exp == 1) ? ad : bd;
            gq.push_back(g);
            if (g.wen == 4'd0) begin
                r.who  = exp;
                r.data = memf(g.addr);
                r.due  = cnt + 1;
                rq.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 0, 0);
    endtask

    initial begin
        gexp_t g;
        reset = 1'b0;
        a_req = 1'b1; a_wen = 4'd0; a_addr = 32'h44; a_wdata = 32'h0;
        b_req = 1'b1; b_wen = 4'hF; b_addr = 32'h48; b_wdata = 32'h55;
        b_lock = 1'b1;
        @(negedge clk);
        chk_zero("reset_outputs");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        // Contention: A first, B forced in after MAX_WAIT denied cycles, A again.
        for (int i = 0; i < 6; i++)
            cyc(1, 4'd0, 32'h1000 + 32'(i * 4), 32'd0,
                1, 4'd0, 32'h2000 + 32'(i * 4), 32'd0, 0, (i == 4) ? 2 : 1);
        idle(1);

        cyc(0, 4'd0, 32'd0, 32'd0, 1, 4'd0, 32'h100, 32'd0, 0, 2);
        idle(1);

        cyc(1, 4'b0011, 32'h20, 32'h12345678, 0, 4'd0, 32'd0, 32'd0, 0, 1);
        idle(2);

        // b_lock is ignored until B owns the port, then holds it until dropped.
        for (int i = 0; i < 8; i++)
            cyc(1, 4'd0, 32'h3000 + 32'(i * 4), 32'd0,
                1, 4'hF, 32'h4000 + 32'(i * 4), 32'hB0000000 + 32'(i),
                (i < 7), (i < 4) ? 1 : ((i < 7) ? 2 : 1));
        idle(1);

        // Reset lands while an A read is pending and while A is still requesting.
        a_req = 1'b1; a_wen = 4'd0; a_addr = 32'h300; a_wdata = 32'd0;
        b_req = 1'b0; b_lock = 1'b0;
        g.who = 1; g.wen = 4'd0; g.addr = 32'h300; g.wdata = 32'd0;
        gq.push_back(g);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_zero("reset_pending_read");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3);

        chk("grant_queue_drained", 64'(gq.size()), 64'd0);
        chk("read_queue_drained", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
